// File: rtl/ov2640_pkg.sv
// Shared constants and state encodings for the OV2640 power-up / SCCB configuration block.
package ov2640_pkg;

    localparam logic [15:0] ROM_END       = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY     = 16'hFFF0;
    localparam logic [7:0]  OV2640_DEV_ID = 8'h60;

    typedef enum logic [3:0] {
        CFG_IDLE   = 4'd0,
        CFG_HWRST  = 4'd1,
        CFG_BOOT   = 4'd2,
        CFG_FETCH  = 4'd3,
        CFG_DECODE = 4'd4,
        CFG_DELAY  = 4'd5,
        CFG_WRITE  = 4'd6,
        CFG_NEXT   = 4'd7,
        CFG_FINISH = 4'd8
    } cfg_state_t;

    typedef enum logic [2:0] {
        ENG_IDLE      = 3'd0,
        ENG_START     = 3'd1,
        ENG_BIT_LO    = 3'd2,
        ENG_BIT_HI    = 3'd3,
        ENG_STOP_LO   = 3'd4,
        ENG_STOP_HI   = 3'd5,
        ENG_STOP_FREE = 3'd6
    } eng_phase_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sccb_write_engine.sv
// SCCB 3-phase write engine: START, {DEV_ID, reg, val} each followed by a released
// don't-care bit, then STOP and one quarter-pair of bus-free time before wr_done.
module sccb_write_engine
    import ov2640_pkg::*;
#(
    parameter int         SCCB_QTR = 125,
    parameter logic [7:0] DEV_ID   = OV2640_DEV_ID
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_start,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_reg_val,
    output logic       o_sio_c,
    output logic       o_sio_d_out,
    output logic       o_sio_d_oe,
    output logic       o_busy,
    output logic       o_wr_done
);

    localparam int             QW           = $clog2(2 * SCCB_QTR);
    localparam logic [QW-1:0]  L_QTR        = QW'(SCCB_QTR - 1);
    localparam logic [QW-1:0]  L_HALF       = QW'(2 * SCCB_QTR - 1);
    // Drive mask per bit slot, MSB first: the 9th slot of each phase is released.
    localparam logic [26:0]    L_DRIVE_MASK = 27'b111111110_111111110_111111110;

    eng_phase_t     r_phase;
    logic [QW-1:0]  r_qcnt;
    logic [4:0]     r_bit_idx;
    logic [26:0]    r_shift;
    logic [26:0]    r_drive;
    logic           r_sio_c;
    logic           r_sio_d;
    logic           r_sio_oe;
    logic           r_wr_done;
    logic           w_cnt_qtr;
    logic           w_cnt_end;

    assign w_cnt_qtr   = (r_qcnt == L_QTR);
    assign w_cnt_end   = (r_qcnt == L_HALF);
    assign o_sio_c     = r_sio_c;
    assign o_sio_d_out = r_sio_d;
    assign o_sio_d_oe  = r_sio_oe;
    assign o_busy      = (r_phase != ENG_IDLE);
    assign o_wr_done   = r_wr_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase   <= ENG_IDLE;
            r_qcnt    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_drive   <= '0;
            r_sio_c   <= 1'b1;
            r_sio_d   <= 1'b1;
            r_sio_oe  <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            if (r_phase != ENG_IDLE) begin
                r_qcnt <= w_cnt_end ? '0 : r_qcnt + 1'b1;
            end
            case (r_phase)
                ENG_IDLE: begin
                    if (i_wr_start) begin
                        r_phase   <= ENG_START;
                        r_qcnt    <= '0;
                        r_bit_idx <= '0;
                        r_sio_oe  <= 1'b1;
                        r_sio_d   <= 1'b0;
                        r_shift   <= {DEV_ID, 1'b1, i_reg_addr, 1'b1, i_reg_val, 1'b1};
                        r_drive   <= L_DRIVE_MASK;
                    end
                end
                ENG_START: begin
                    if (w_cnt_end) begin
                        r_phase <= ENG_BIT_LO;
                        r_sio_c <= 1'b0;
                    end
                end
                ENG_BIT_LO: begin
                    // Data moves mid-way through the low half so it is settled well before SIO_C rises.
                    if (w_cnt_qtr) begin
                        r_sio_d  <= r_shift[26];
                        r_sio_oe <= r_drive[26];
                    end
                    if (w_cnt_end) begin
                        r_phase <= ENG_BIT_HI;
                        r_sio_c <= 1'b1;
                    end
                end
                ENG_BIT_HI: begin
                    if (w_cnt_end) begin
                        r_sio_c <= 1'b0;
                        r_shift <= {r_shift[25:0], 1'b1};
                        r_drive <= {r_drive[25:0], 1'b0};
                        if (r_bit_idx == 5'd26) begin
                            r_phase  <= ENG_STOP_LO;
                            r_sio_oe <= 1'b1;
                            r_sio_d  <= 1'b0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 5'd1;
                            r_phase   <= ENG_BIT_LO;
                        end
                    end
                end
                ENG_STOP_LO: begin
                    if (w_cnt_end) begin
                        r_phase <= ENG_STOP_HI;
                        r_sio_c <= 1'b1;
                    end
                end
                ENG_STOP_HI: begin
                    if (w_cnt_end) begin
                        r_phase  <= ENG_STOP_FREE;
                        r_sio_oe <= 1'b0;
                        r_sio_d  <= 1'b1;
                    end
                end
                ENG_STOP_FREE: begin
                    if (w_cnt_end) begin
                        r_phase   <= ENG_IDLE;
                        r_wr_done <= 1'b1;
                    end
                end
                default: r_phase <= ENG_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ov2640_sccb_config.sv
// OV2640 power-up sequencer: PWDN/RESETB timing, boot wait, then walks the config ROM
// issuing one SCCB write per {reg,val} entry, with FFF0 delay and FFFF end markers.
module ov2640_sccb_config
    import ov2640_pkg::*;
#(
    parameter logic [7:0] DEV_ID       = OV2640_DEV_ID,
    parameter int         SCCB_QTR     = 125,
    parameter int         RESET_CYCLES = 50_000,
    parameter int         BOOT_CYCLES  = 500_000,
    parameter int         DELAY_CYCLES = 500_000,
    parameter int         ROM_AW       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sio_c,
    output logic              o_sio_d_out,
    output logic              o_sio_d_oe,
    output logic              o_cam_pwdn,
    output logic              o_cam_resetb,
    output logic              o_cfg_busy,
    output logic              o_cfg_done,
    output logic [3:0]        o_cfg_state
);

    localparam int CW = $clog2(max3(RESET_CYCLES, BOOT_CYCLES, DELAY_CYCLES) + 1);

    cfg_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [ROM_AW-1:0]  r_rom_addr;
    logic               r_pwdn;
    logic               r_resetb;
    logic               r_busy;
    logic               r_done;
    logic               w_is_end;
    logic               w_is_delay;
    logic               w_wr_start;
    logic               w_wr_done;
    logic               w_eng_busy;

    // Engine handshake: w_wr_start is a one-cycle request taken only while the engine is
    // idle; w_wr_done is a one-cycle completion after the bus is free again.
    assign w_is_end   = (i_rom_data == ROM_END);
    assign w_is_delay = (i_rom_data == ROM_DELAY);
    assign w_wr_start = (r_state == CFG_DECODE) && !w_is_end && !w_is_delay && !w_eng_busy;

    assign o_rom_addr   = r_rom_addr;
    assign o_cam_pwdn   = r_pwdn;
    assign o_cam_resetb = r_resetb;
    assign o_cfg_busy   = r_busy;
    assign o_cfg_done   = r_done;
    assign o_cfg_state  = r_state;

    sccb_write_engine #(
        .SCCB_QTR (SCCB_QTR),
        .DEV_ID   (DEV_ID)
    ) u_engine (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_start  (w_wr_start),
        .i_reg_addr  (i_rom_data[15:8]),
        .i_reg_val   (i_rom_data[7:0]),
        .o_sio_c     (o_sio_c),
        .o_sio_d_out (o_sio_d_out),
        .o_sio_d_oe  (o_sio_d_oe),
        .o_busy      (w_eng_busy),
        .o_wr_done   (w_wr_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= CFG_IDLE;
            r_cnt      <= '0;
            r_rom_addr <= '0;
            r_pwdn     <= 1'b1;
            r_resetb   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                CFG_IDLE: begin
                    if (i_start) begin
                        r_state    <= CFG_HWRST;
                        r_pwdn     <= 1'b0;
                        r_resetb   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_cnt      <= '0;
                        r_rom_addr <= '0;
                    end
                end
                CFG_HWRST: begin
                    if (r_cnt == CW'(RESET_CYCLES - 1)) begin
                        r_resetb <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= CFG_BOOT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CFG_BOOT: begin
                    if (r_cnt == CW'(BOOT_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= CFG_FETCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // ROM data is registered on the address, so give it one cycle to arrive.
                CFG_FETCH: r_state <= CFG_DECODE;
                CFG_DECODE: begin
                    if (w_is_end) begin
                        r_state <= CFG_FINISH;
                    end else if (w_is_delay) begin
                        r_cnt   <= '0;
                        r_state <= CFG_DELAY;
                    end else if (!w_eng_busy) begin
                        r_state <= CFG_WRITE;
                    end
                end
                CFG_DELAY: begin
                    if (r_cnt == CW'(DELAY_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= CFG_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CFG_WRITE: begin
                    if (w_wr_done) begin
                        r_state <= CFG_NEXT;
                    end
                end
                CFG_NEXT: begin
                    if (r_rom_addr == '1) begin
                        r_state <= CFG_FINISH;
                    end else begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                        r_state    <= CFG_FETCH;
                    end
                end
                CFG_FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= CFG_IDLE;
                end
                default: r_state <= CFG_IDLE;
            endcase
        end
    end

endmodule
